mult_div_unit: RTL

- Multicycle signed multiply/divide unit that sits beside the ALU and consumes the same operand registers A and B that feed the ALU source muxes.
- It is driven by one-cycle start pulses from the control unit.
- It iterates one bit per clock and writes the 64-bit result into internal HI/LO registers for later mfhi/mflo.
- It raises busy while working and pulses done so the control FSM can leave its wait state.

---
 rtl/mult_div_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / restoring divide unit with HI/LO result registers.
// Define MULDIV_UNSIGNED_EN to honour is_unsigned (multu/divu); otherwise every operation is signed.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             is_unsigned,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH-1:0] r_m;
    logic             r_negQ;
    logic             r_negR;
    logic             r_divZero;
    logic             r_unsigned;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_opUnsigned;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH:0]   w_mExt;
    logic [WIDTH:0]   w_sum;
    logic             w_fill;
    logic [WIDTH:0]   w_accMul;
    logic [WIDTH-1:0] w_qMul;
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_accDiv;
    logic [WIDTH-1:0] w_qDiv;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

`ifdef MULDIV_UNSIGNED_EN
    assign w_opUnsigned = is_unsigned;
`else
    assign w_opUnsigned = is_unsigned & 1'b0;
`endif

    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && (start_mult || start_div);
    assign w_last   = (r_count == CW'(WIDTH - 1));
    assign w_absA   = (A[WIDTH-1] && !w_opUnsigned) ? -A : A;
    assign w_absB   = (B[WIDTH-1] && !w_opUnsigned) ? -B : B;

    // One iteration of each algorithm; the accumulator carries an extra bit so Booth never overflows.
    always_comb begin
        w_mExt = r_unsigned ? {1'b0, r_m} : {r_m[WIDTH-1], r_m};
        w_sum  = r_acc;
        if (r_unsigned) begin
            if (r_q[0]) begin
                w_sum = r_acc + w_mExt;
            end
        end else begin
            case ({r_q[0], r_qm1})
                2'b01:   w_sum = r_acc + w_mExt;
                2'b10:   w_sum = r_acc - w_mExt;
                default: w_sum = r_acc;
            endcase
        end
        w_fill   = r_unsigned ? 1'b0 : w_sum[WIDTH];
        w_accMul = {w_fill, w_sum[WIDTH:1]};
        w_qMul   = {w_sum[0], r_q[WIDTH-1:1]};

        w_remShift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_diff     = w_remShift - {1'b0, r_m};
        if (!w_diff[WIDTH]) begin
            w_accDiv = w_diff;
            w_qDiv   = {r_q[WIDTH-2:0], 1'b1};
        end else begin
            w_accDiv = w_remShift;
            w_qDiv   = {r_q[WIDTH-2:0], 1'b0};
        end
        w_quot = r_negQ ? -w_qDiv : w_qDiv;
        w_rem  = r_negR ? -w_accDiv[WIDTH-1:0] : w_accDiv[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        div_zero    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done        = (r_state == DONE);
                div_zero    = (r_state == DONE) && r_divZero;
                w_nextState = IDLE;
                if (start_mult) begin
                    w_nextState = MULT;
                end else if (start_div) begin
                    w_nextState = (B == '0) ? DONE : DIV;
                end
            end
            MULT, DIV: begin
                busy = 1'b1;
                if (w_last) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Operands are captured at the accepting edge; HI/LO only move on the final iteration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_qm1      <= 1'b0;
            r_m        <= '0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
            r_divZero  <= 1'b0;
            r_unsigned <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (w_accept) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_qm1      <= 1'b0;
            r_unsigned <= w_opUnsigned;
            if (start_mult) begin
                r_m       <= A;
                r_q       <= B;
                r_negQ    <= 1'b0;
                r_negR    <= 1'b0;
                r_divZero <= 1'b0;
            end else begin
                r_m       <= w_absB;
                r_q       <= w_absA;
                r_negQ    <= !w_opUnsigned && (A[WIDTH-1] ^ B[WIDTH-1]);
                r_negR    <= !w_opUnsigned && A[WIDTH-1];
                r_divZero <= (B == '0);
            end
        end else if (r_state == MULT) begin
            r_count <= r_count + CW'(1);
            r_acc   <= w_accMul;
            r_q     <= w_qMul;
            r_qm1   <= r_q[0];
            if (w_last) begin
                r_hi <= w_accMul[WIDTH-1:0];
                r_lo <= w_qMul;
            end
        end else if (r_state == DIV) begin
            r_count <= r_count + CW'(1);
            r_acc   <= w_accDiv;
            r_q     <= w_qDiv;
            if (w_last) begin
                r_hi <= w_rem;
                r_lo <= w_quot;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
